leiwand_rv32_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the native valid/ready memory bus.
- Master 0 is the CPU core. Master 1 is a secondary requester such as a DMA or debug loader.
- Grants are round-robin, and a grant is held until the slave completes the transfer.
- A watchdog completes any access to an unmapped address, so the bus cannot hang on a never-asserted ready.
- Sits between the requesters and the existing address-decoded RAM/flash/GPIO/IRQ fabric.

---
 rtl/leiwand_rv32_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_leiwand_rv32_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Grants are held until the slave completes; a watchdog completes unanswered accesses.
module leiwand_rv32_bus_arbiter #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [ADDR_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wen,
    output logic [ADDR_W-1:0] m0_rdata,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [ADDR_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wen,
    output logic [ADDR_W-1:0] m1_rdata,

    output logic              s_valid,
    input  logic              s_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] s_wdata,
    output logic [3:0]        s_wen,
    input  logic [ADDR_W-1:0] s_rdata,

    output logic [1:0]        grant,
    output logic              bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] LP_TLIM = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_grant;
    logic        r_last;
    logic [15:0] r_timer;

    logic              w_gvalid;
    logic              w_timeout;
    logic              w_done;
    logic [ADDR_W-1:0] w_rdata;

    always_comb begin
        w_gvalid  = (r_state == BUSY) &
                    ((r_grant[0] & m0_valid) | (r_grant[1] & m1_valid));
        // s_ready wins over a coincident watchdog expiry
        w_timeout = w_gvalid & ~s_ready & (r_timer == LP_TLIM);
        w_done    = (w_gvalid & s_ready) | w_timeout;
        w_rdata   = w_timeout ? ERR_DATA : s_rdata;
    end

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wen   = '0;
        if (r_grant[0]) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wen   = m0_wen;
        end else if (r_grant[1]) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wen   = m1_wen;
        end
    end

    always_comb begin
        s_valid  = w_gvalid & ~w_timeout;
        m0_ready = r_grant[0] & w_done;
        m1_ready = r_grant[1] & w_done;
        m0_rdata = r_grant[0] ? w_rdata : '0;
        m1_rdata = r_grant[1] ? w_rdata : '0;
        bus_err  = w_timeout;
        grant    = r_grant;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= 1'b1;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    // on a tie the master that was not served last wins
                    if (m0_valid && (!m1_valid || r_last)) begin
                        r_grant <= 2'b01;
                        r_state <= BUSY;
                    end else if (m1_valid) begin
                        r_grant <= 2'b10;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_gvalid) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_timer <= '0;
                    end else if (w_done) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_timer <= '0;
                        r_last  <= r_grant[1];
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// Scoreboard bench for leiwand_rv32_bus_arbiter: random masters, latency-randomised
// slave model, round-robin reference, then directed reset/tie/violation/timeout cases.
module tb_leiwand_rv32_bus_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_valid, m0_ready, m1_valid, m1_ready;
    logic [AW-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]    m0_wen, m1_wen, s_wen;
    logic          s_valid, s_ready, bus_err;
    logic [AW-1:0] s_addr, s_wdata, s_rdata;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    leiwand_rv32_bus_arbiter #(.ADDR_W(AW), .TIMEOUT(TO), .ERR_DATA(ERRD)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wen(m0_wen), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wen(m1_wen), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wen(s_wen), .s_rdata(s_rdata),
        .grant(grant), .bus_err(bus_err)
    );

    typedef struct { logic [31:0] rdata; bit err; } mresp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wen; } sreq_t;

    mresp_t exp_m0[$], exp_m1[$];
    sreq_t  exp_s0[$], exp_s1[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit       mon_en = 1'b0;
    bit       seen0 = 1'b0, seen1 = 1'b0;
    bit       last_model = 1'b1;
    bit       v0_prev = 1'b0, v1_prev = 1'b0, done_prev = 1'b0;
    logic [1:0] g_prev = 2'b00;
    bit       sl_to_now = 1'b0;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: answers mapped addresses after a random 0..TO-1 cycle latency, never unmapped ones.
    bit          sl_active = 1'b0, sl_map = 1'b0;
    int          sl_k = 0, sl_lat = 0;
    logic [31:0] sl_addr = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            sl_active = 1'b0;
            s_ready   = 1'b0;
            sl_to_now = 1'b0;
        end else begin
            if (!sl_active && s_valid) begin
                sl_active = 1'b1;
                sl_k      = 0;
                sl_lat    = int'($urandom_range(TO - 1, 0));
                sl_addr   = s_addr;
                sl_map    = !unmapped(s_addr);
            end else if (sl_active && !s_valid && sl_k < int'(TO - 1)) begin
                sl_active = 1'b0;
            end
            s_ready   = 1'b0;
            sl_to_now = 1'b0;
            s_rdata   = $urandom;
            if (sl_active) begin
                if (sl_map && sl_k == sl_lat) begin
                    s_ready   = 1'b1;
                    s_rdata   = slv_data(sl_addr);
                    sl_active = 1'b0;
                end else begin
                    if (!sl_map && sl_k == int'(TO - 1)) sl_to_now = 1'b1;
                    if (sl_k == int'(TO - 1)) sl_active = 1'b0;
                    else sl_k++;
                end
            end
        end
    end

    // Monitor: compares every observable completion against the scoreboard queues.
    always @(negedge clk) begin
        mresp_t     r;
        sreq_t      s;
        logic [1:0] exp_g;
        #2;
        if (mon_en) begin
            check("bus_err", bus_err, sl_to_now);
            if (g_prev == 2'b00 && grant != 2'b00) begin
                if (v0_prev && v1_prev) exp_g = last_model ? 2'b01 : 2'b10;
                else                    exp_g = v0_prev ? 2'b01 : 2'b10;
                check("grant_entry", grant, exp_g);
            end
            if (done_prev) check("turnaround_grant", grant, 2'b00);
            if (grant == 2'b00) check("idle_svalid", s_valid, 1'b0);
            if (m0_ready) begin
                if (exp_m0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL m0_unexpected_ready: got 1 expected 0 at %0t", $time);
                end else begin
                    r = exp_m0.pop_front();
                    check("m0_rdata", m0_rdata, r.rdata);
                    check("m0_err", bus_err, r.err);
                    if (r.err) check("m0_to_svalid", s_valid, 1'b0);
                end
                check("m1_ready_excl", m1_ready, 1'b0);
                check("m1_rdata_zero", m1_rdata, '0);
                last_model = 1'b0;
                seen0 = 1'b1;
            end
            if (m1_ready) begin
                if (exp_m1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL m1_unexpected_ready: got 1 expected 0 at %0t", $time);
                end else begin
                    r = exp_m1.pop_front();
                    check("m1_rdata", m1_rdata, r.rdata);
                    check("m1_err", bus_err, r.err);
                    if (r.err) check("m1_to_svalid", s_valid, 1'b0);
                end
                check("m0_ready_excl", m0_ready, 1'b0);
                check("m0_rdata_zero", m0_rdata, '0);
                last_model = 1'b1;
                seen1 = 1'b1;
            end
            if (s_valid && s_ready) begin
                if ((s_addr[24] ? exp_s1.size() : exp_s0.size()) == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL s_unexpected: got addr %h expected none at %0t", s_addr, $time);
                end else begin
                    s = s_addr[24] ? exp_s1.pop_front() : exp_s0.pop_front();
                    check("s_addr", s_addr, s.addr);
                    check("s_wdata", s_wdata, s.wdata);
                    check("s_wen", s_wen, s.wen);
                end
            end
            done_prev = m0_ready | m1_ready;
            g_prev    = grant;
            v0_prev   = m0_valid;
            v1_prev   = m1_valid;
        end
    end

    task automatic drive(input int id, input int n, input int gapmax);
        for (int t = 0; t < n; t++) begin
            logic [31:0] a, wd, rnd;
            logic [3:0]  we;
            mresp_t      r;
            sreq_t       s;
            int          g, w;
            g = int'($urandom_range(gapmax, 0));
            if (g > 0) begin
                if (id == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            rnd = $urandom;
            a   = {($urandom_range(5, 0) == 0) ? 4'hF : 4'h2, 3'b000, id[0], rnd[21:0], 2'b00};
            wd  = $urandom;
            we  = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            r.rdata = unmapped(a) ? ERRD : slv_data(a);
            r.err   = unmapped(a);
            s.addr = a; s.wdata = wd; s.wen = we;
            if (id == 0) begin
                exp_m0.push_back(r);
                if (!unmapped(a)) exp_s0.push_back(s);
                seen0 = 1'b0;
                m0_addr = a; m0_wdata = wd; m0_wen = we; m0_valid = 1'b1;
            end else begin
                exp_m1.push_back(r);
                if (!unmapped(a)) exp_s1.push_back(s);
                seen1 = 1'b0;
                m1_addr = a; m1_wdata = wd; m1_wen = we; m1_valid = 1'b1;
            end
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!(id == 0 ? seen0 : seen1) && w < 100);
            if (!(id == 0 ? seen0 : seen1)) begin
                n_cmp++; n_bad++;
                $display("FAIL m%0d_hang: got no ready expected ready within 100 cycles", id);
            end else begin
                check($sformatf("m%0d_wait_bound", id), 32'(w <= int'(2 * TO + 3)), 32'd1);
            end
            if (id == 0) seen0 = 1'b0; else seen1 = 1'b0;
        end
        if (id == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
    endtask

    task automatic wait_rdy(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (id == 0 ? m0_ready : m1_ready) begin
                ok = 1'b1;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL m%0d_directed_wait: got no ready expected ready within 40 cycles", id);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit ok;
        int busy_cyc;
        m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wen = '0;
        m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wen = '0;
        s_ready = 0; s_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_svalid", s_valid, 1'b0);
        check("rst_m0_ready", m0_ready, 1'b0);
        check("rst_m1_ready", m1_ready, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_s_addr", s_addr, '0);
        check("rst_s_wen", s_wen, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        fork
            drive(0, 30, 2);
            drive(1, 30, 2);
        join
        fork
            drive(0, 20, 0);
            drive(1, 20, 0);
        join
        repeat (6) @(posedge clk);
        check("q_m0_empty", exp_m0.size(), 0);
        check("q_m1_empty", exp_m1.size(), 0);
        check("q_s0_empty", exp_s0.size(), 0);
        check("q_s1_empty", exp_s1.size(), 0);
        mon_en = 1'b0;
        #1;

        // asynchronous reset in the middle of a transfer
        m0_addr = 32'hF000_0010; m0_wen = 4'h0; m0_valid = 1'b1;
        @(posedge clk); #1;
        check("arst_pre_grant", grant, 2'b01);
        check("arst_pre_svalid", s_valid, 1'b1);
        #3 resetn = 1'b0;
        #1;
        check("arst_svalid", s_valid, 1'b0);
        check("arst_grant", grant, 2'b00);
        check("arst_m0_ready", m0_ready, 1'b0);
        check("arst_s_addr", s_addr, '0);
        m0_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // tie after reset: m0 first, then m1 even though m0 re-requests
        m0_addr = 32'h2040_0000; m0_wen = 4'h0; m0_valid = 1'b1;
        m1_addr = 32'h2100_0004; m1_wen = 4'h0; m1_valid = 1'b1;
        @(posedge clk); #1;
        check("tie_first_grant", grant, 2'b01);
        wait_rdy(0, ok);
        if (ok) check("tie_m0_rdata", m0_rdata, slv_data(32'h2040_0000));
        @(posedge clk); #1;
        m0_addr = 32'h2040_0008;
        check("tie_idle_grant", grant, 2'b00);
        @(posedge clk); #1;
        check("tie_second_grant", grant, 2'b10);
        wait_rdy(1, ok);
        if (ok) check("tie_m1_rdata", m1_rdata, slv_data(32'h2100_0004));
        @(posedge clk); #1;
        m1_valid = 1'b0;
        @(posedge clk); #1;
        check("tie_third_grant", grant, 2'b01);
        wait_rdy(0, ok);
        if (ok) check("tie_m0b_rdata", m0_rdata, slv_data(32'h2040_0008));
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(posedge clk); #1;

        // m1 abandons its request: arbiter idles without crediting m1 as served
        m1_addr = 32'hF100_0000; m1_valid = 1'b1;
        @(posedge clk); #1;
        check("viol_grant", grant, 2'b10);
        m1_valid = 1'b0;
        #1;
        check("viol_svalid", s_valid, 1'b0);
        @(posedge clk); #1;
        check("viol_idle", grant, 2'b00);
        m0_addr = 32'h2040_0100; m0_valid = 1'b1;
        m1_addr = 32'h2100_0200; m1_valid = 1'b1;
        @(posedge clk); #1;
        check("viol_tie_grant", grant, 2'b10);
        wait_rdy(1, ok);
        @(posedge clk); #1;
        m1_valid = 1'b0;
        wait_rdy(0, ok);
        if (ok) check("viol_m0_rdata", m0_rdata, slv_data(32'h2040_0100));
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(posedge clk); #1;

        // watchdog on an unmapped read from m1
        m1_addr = 32'hF000_0000; m1_wen = 4'h0; m1_valid = 1'b1;
        busy_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #2;
            if (grant != 2'b00) busy_cyc++;
            if (m1_ready) begin
                ok = 1'b1;
                check("to_rdata", m1_rdata, ERRD);
                check("to_bus_err", bus_err, 1'b1);
                check("to_svalid", s_valid, 1'b0);
                check("to_busy_cycles", busy_cyc, TO);
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL to_wait: got no ready expected ready within 40 cycles");
        end
        @(posedge clk); #1;
        m1_valid = 1'b0;
        check("to_idle_grant", grant, 2'b00);
        check("to_err_pulse", bus_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
